// File: rtl/m_fetch_queue_pkg.sv
// Shared processor constants used by the fetch queue and the surrounding pipeline.
// Holds the NOP encoding, the default word-address width and branch opcodes.
package m_fetch_queue_pkg;

    localparam int          AW_DEFAULT = 11;
    localparam logic [31:0] NOP_IR     = 32'h0000_0020;
    localparam logic [5:0]  OP_BEQ     = 6'b000100;
    localparam logic [5:0]  OP_BNE     = 6'b000101;

    function automatic logic is_cond_branch(input logic [31:0] ir);
        return (ir[31:26] == OP_BEQ) || (ir[31:26] == OP_BNE);
    endfunction

endpackage

// File: rtl/m_fetch_queue_if.sv
// Handshake bundle between IF (master side) and the fetch queue (slave side),
// including the queue's ID-facing head outputs and status counters.
interface m_fetch_queue_if #(
    parameter int AW    = m_fetch_queue_pkg::AW_DEFAULT,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          w_flush;
    logic          w_in_valid;
    logic          w_in_ready;
    logic [AW-1:0] w_in_pc;
    logic [31:0]   w_in_ir;
    logic          w_in_pr;
    logic          w_out_valid;
    logic          w_out_ready;
    logic [AW-1:0] w_out_pc;
    logic [31:0]   w_out_ir;
    logic          w_out_pr;
    logic [CW-1:0] w_count;
    logic [7:0]    w_flush_cnt;

    modport master (
        output w_flush, w_in_valid, w_in_pc, w_in_ir, w_in_pr, w_out_ready,
        input  w_in_ready, w_out_valid, w_out_pc, w_out_ir, w_out_pr, w_count, w_flush_cnt
    );

    modport slave (
        input  w_flush, w_in_valid, w_in_pc, w_in_ir, w_in_pr, w_out_ready,
        output w_in_ready, w_out_valid, w_out_pc, w_out_ir, w_out_pr, w_count, w_flush_cnt
    );

endinterface

// File: rtl/m_fetch_queue.sv
// Instruction fetch queue between instruction memory and the ID pipe registers.
// Register-array FIFO of {pc, ir, pr}; an EX mispredict flush empties it in one cycle.
module m_fetch_queue
    import m_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEFAULT
) (
    input logic         w_clk,
    input logic         w_rst_n,
    m_fetch_queue_if.slave fq
);

    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [7:0]    flush_cnt;

    logic [AW-1:0] pc_mem [DEPTH];
    logic [31:0]   ir_mem [DEPTH];
    logic          pr_mem [DEPTH];

    logic do_enq;
    logic do_deq;
    logic out_valid;

    // Ready is gated by reset so it drops the instant reset asserts and rises right after release.
    assign out_valid = (count != '0);
    assign do_enq    = fq.w_in_valid && fq.w_in_ready;
    assign do_deq    = out_valid && fq.w_out_ready;

    assign fq.w_in_ready  = w_rst_n && (count < FULL) && !fq.w_flush;
    assign fq.w_out_valid = out_valid;
    assign fq.w_count     = count;
    assign fq.w_flush_cnt = flush_cnt;

    // Empty slots are masked so stale storage never reaches ID.
    assign fq.w_out_pc = out_valid ? pc_mem[rd_ptr] : '0;
    assign fq.w_out_ir = out_valid ? ir_mem[rd_ptr] : NOP_IR;
    assign fq.w_out_pr = out_valid ? pr_mem[rd_ptr] : 1'b0;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            flush_cnt <= '0;
        end else if (fq.w_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if ((count != '0) && (flush_cnt != 8'hFF)) begin
                flush_cnt <= flush_cnt + 8'd1;
            end
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_enq && !do_deq) begin
                count <= count + (PW + 1)'(1);
            end else if (!do_enq && do_deq) begin
                count <= count - (PW + 1)'(1);
            end
        end
    end

    // Storage is not reset; do_enq already excludes flush and reset cycles.
    always_ff @(posedge w_clk) begin
        if (do_enq) begin
            pc_mem[wr_ptr] <= fq.w_in_pc;
            ir_mem[wr_ptr] <= fq.w_in_ir;
            pr_mem[wr_ptr] <= fq.w_in_pr;
        end
    end

endmodule

// File: doc/m_fetch_queue.md
M_FETCH_QUEUE -- requirements
Module: m_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL be the number of entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter AW, default 11, SHALL be the instruction word-address width.
REQ-003 w_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 w_rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 w_flush  input  1  SHALL signal an EX-stage mispredict; the queue discards all entries.
REQ-006 w_in_valid  input  1  SHALL mark a fetched instruction offered by IF.
REQ-007 w_in_ready  output  1  SHALL mark that the queue accepts an entry this cycle.
REQ-008 w_in_pc  input  AW  SHALL be the fetch address.
REQ-009 w_in_ir  input  32  SHALL be the fetched instruction word.
REQ-010 w_in_pr  input  1  SHALL be the IF predicted-taken bit.
REQ-011 w_out_valid  output  1  SHALL mark a head entry presented to ID.
REQ-012 w_out_ready  input  1  SHALL mark that ID consumes the head this cycle.
REQ-013 w_out_pc / w_out_ir / w_out_pr  output  AW/32/1  SHALL be the head entry fields.
REQ-014 w_count  output  clog2(DEPTH)+1  SHALL be the current occupancy.
REQ-015 w_flush_cnt  output  8  SHALL be the saturating count of flushes that discarded at least one entry.

Function
REQ-016 Enqueue SHALL occur when w_in_valid && w_in_ready; dequeue SHALL occur when w_out_valid && w_out_ready.
REQ-017 w_in_ready SHALL equal (w_count < DEPTH) && !w_flush, independent of w_out_ready (no enqueue while full, even with a simultaneous dequeue).
REQ-018 w_out_valid SHALL equal (w_count != 0); no bypass: an entry enqueued in cycle N is first visible in cycle N+1.
REQ-019 When w_out_valid=0, w_out_ir SHALL be 32'h20 (NOP), w_out_pr 0, w_out_pc 0.
REQ-020 Entries SHALL leave in strict FIFO order with pc, ir and pr kept together.
REQ-021 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-022 A simultaneous enqueue and dequeue SHALL leave w_count unchanged and advance both pointers.
REQ-023 On a cycle with w_flush=1, the next state SHALL be: w_count=0 and both pointers 0; any enqueue or dequeue in that cycle has no effect.
REQ-024 w_flush_cnt SHALL increment when w_flush=1 and w_count!=0, and SHALL hold at 255.
REQ-025 Storage contents of non-valid slots SHALL never be observable on the outputs.

Reset
REQ-026 Asserting w_rst_n=0 SHALL immediately force w_count=0, pointers=0, w_flush_cnt=0, w_out_valid=0, w_in_ready=0, and w_out_ir=NOP, regardless of the clock.
REQ-027 Reset asserted mid-operation SHALL discard all entries without completing any pending handshake.
REQ-028 w_in_ready SHALL rise in the first cycle after w_rst_n deasserts.
REQ-029 Storage array contents SHALL NOT require reset.

Structure
REQ-030 The NOP encoding (32'h20), the AW default, and the BEQ/BNE opcodes SHALL live in the shared processor package.
REQ-031 The block SHALL be a single module with a register-array storage; no sub-module.
REQ-032 In the pipeline, the block SHALL sit between the instruction-memory output and the ID pipe registers; w_flush SHALL be driven by the EX mispredict signal.

Verification
REQ-033 Fill: after reset, 4 back-to-back enqueues pc=0..3, w_out_ready=0 -> w_count=4, w_in_ready=0, head pc=0.
REQ-034 Drain order: from a full queue, w_out_ready=1 for 4 cycles -> pc 0,1,2,3 in order, then w_out_valid=0 and w_out_ir=32'h20.
REQ-035 Streaming: continuous enqueue and dequeue for 10 cycles from a 2-entry occupancy -> w_count stays 2 and pointers wrap with no loss.
REQ-036 Flush with enqueue: 3 entries present, w_flush=1 and w_in_valid=1 -> next cycle w_count=0, w_flush_cnt=1, the offered entry is absent.
REQ-037 Flush when empty: w_flush=1 with w_count=0 -> w_flush_cnt unchanged; 300 flushes with entries present -> w_flush_cnt=255.
REQ-038 Async reset: w_rst_n pulsed low between clock edges with 2 entries present -> outputs reset immediately, before the next edge.
